parallel_io_ctrl: RTL and testbench
===================================

Name: parallel_io_ctrl

Overview:
Parametrised memory-mapped parallel I/O controller for the single-cycle 8-bit core. It replaces the fixed one-input/one-output ParallelIN/ParallelOUT pair with N_IN synchronised input channels, N_OUT registered output channels and a sticky change-status register. It sits between the ALU address/rd2 path, the data RAM and the MemtoReg mux. It owns data-RAM write gating and read-data selection for the whole I/O window.

Parameters:
DATA_W, 8, width of every data channel and bus
ADDR_W, 8, data address width
N_IN, 2, number of input channels (1..8)
N_OUT, 2, number of output channels (1..8)
IN_BASE, 8'hF0, address of input channel 0; channel i is at IN_BASE+i
OUT_BASE, 8'hF8, address of output channel 0; channel j is at OUT_BASE+j
STAT_ADDR, 8'hFF, status register address
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
iRST_N  in  1  asynchronous active-low reset
step_en  in  1  one-clk pulse marking the CPU state-update edge; qualifies writes and clear-on-read
address  in  ADDR_W  ALU result, data address
wdata  in  DATA_W  store data (rd2)
we  in  1  MemWrite from control unit
mem_rdata  in  DATA_W  data-RAM q
rdata  out  DATA_W  read data to MemtoReg mux
ram_we  out  1  gated data-RAM write enable
din  in  N_IN*DATA_W  asynchronous external inputs; channel i = din[i*DATA_W +: DATA_W]
dout  out  N_OUT*DATA_W  registered output channels
dout_stb  out  N_OUT  one-clk pulse per channel on update
chg_flags  out  N_IN  sticky change flags, also mirrored to LEDs

Behaviour:
- Reset (iRST_N low, asynchronous): all synchroniser stages, dout, dout_stb and chg_flags go to 0. Release is synchronous to clk.
- Decode: hit_in[i] = (address == IN_BASE+i); hit_out[j] = (address == OUT_BASE+j); hit_stat = (address == STAT_ADDR); io_hit = OR of all. Windows must not overlap; an elaboration check fails if any two overlap.
- ram_we = we & ~io_hit (combinational). A store into the I/O window never reaches the RAM.
- Read path is combinational, with zero latency, for same-cycle single-cycle loads:
  - hit_in[i] gives the synchronised sample sync_in[i].
  - hit_out[j] gives dout[j] (read-back).
  - hit_stat gives chg_flags, zero-extended to DATA_W.
  - Otherwise rdata = mem_rdata.
- Input channel: SYNC_STAGES-deep flop chain per channel on clk. prev[i] holds the last synchronised value. chg_flags[i] sets when sync_in[i] != prev[i].
- Clear-on-read: when step_en & hit_stat & ~we, all flags clear on that clk. If a change is detected in the same clk, set wins and that flag stays 1.
- Output write: when step_en & we & hit_out[j], dout[j] <= wdata on that clk edge, with 1-cycle latency to the pins. dout_stb[j] is 1 for exactly the following clk, then 0.
- Writes to an input address or STAT_ADDR are ignored: no state change and ram_we = 0.
- we without step_en has no effect on any I/O state. ram_we still follows we, because RAM timing is the core's concern.
- Reset asserted mid-operation: dout returns to 0 immediately and any pending strobe is dropped.

Decomposition:
- Shared package pio_pkg holds the default base addresses and an address-overlap check function.
- One sub-module, pio_in_chan: synchroniser, prev register and sticky flag for one channel, instantiated N_IN times with a generate loop.
- Output registers and decode stay in the top module.

Test Plan:
- Reset: hold iRST_N=0 with din=8'hA5 → dout=0, dout_stb=0, chg_flags=0. Release → chg_flags[0] sets SYNC_STAGES+1 clks later.
- Output write: address=8'hF9, wdata=8'h3C, we=1, step_en pulse → dout[1]=8'h3C next clk; dout_stb=2'b10 for one clk; ram_we=0 throughout; reading 8'hF9 returns 8'h3C.
- Write without step_en: address=8'hF8, we=1, step_en=0 → dout unchanged, no strobe.
- Input and status: din ch1 changes 8'h00→8'h7F → rdata at 8'hF1 = 8'h7F after SYNC_STAGES clks. Read 8'hFF → 8'h02. Read again with step_en → flags cleared, next read 8'h00.
- Clear/set collision: a ch0 change reaches prev compare on the same clk as a step_en status read → chg_flags[0] stays 1.
- RAM passthrough: address=8'h10, we=1 → ram_we=1. Read at 8'h10 → rdata = mem_rdata (8'h55).

Source files
------------

// File: rtl/pio_pkg.sv
// Shared defaults and elaboration helpers for the parallel I/O controller.
// The address-window overlap check is evaluated at elaboration time by the top.
package pio_pkg;

  localparam logic [7:0] IN_BASE_DEF   = 8'hF0;
  localparam logic [7:0] OUT_BASE_DEF  = 8'hF8;
  localparam logic [7:0] STAT_ADDR_DEF = 8'hFF;

  // Half-open windows [base, base+n) intersect when each starts before the other ends.
  function automatic bit windows_overlap(input int a_base, input int a_n,
                                         input int b_base, input int b_n);
    return (a_base < b_base + b_n) && (b_base < a_base + a_n);
  endfunction

endpackage

// File: rtl/pio_in_chan.sv
// One input channel: multi-stage synchroniser, last-sample register and a sticky
// change flag. The set term wins over a same-cycle clear.
module pio_in_chan #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              iRST_N,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] sync_out,
  output logic              chg_flag
);

  logic [DATA_W-1:0] sync_p [SYNC_STAGES];
  logic [DATA_W-1:0] prev;

  assign sync_out = sync_p[SYNC_STAGES-1];

  // synchroniser chain -> prev -> sticky flag
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev     <= '0;
      chg_flag <= 1'b0;
    end else begin
      sync_p[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev     <= sync_out;
      chg_flag <= (sync_out != prev) | (chg_flag & ~clr);
    end
  end

endmodule

// File: rtl/parallel_io_ctrl.sv
// Memory-mapped parallel I/O window for the single-cycle core: synchronised
// inputs, registered outputs with strobes, sticky change status, RAM write gating.
module parallel_io_ctrl
  import pio_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               ADDR_W      = 8,
  parameter int               N_IN        = 2,
  parameter int               N_OUT       = 2,
  parameter logic [ADDR_W-1:0] IN_BASE    = ADDR_W'(IN_BASE_DEF),
  parameter logic [ADDR_W-1:0] OUT_BASE   = ADDR_W'(OUT_BASE_DEF),
  parameter logic [ADDR_W-1:0] STAT_ADDR  = ADDR_W'(STAT_ADDR_DEF),
  parameter int               SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    iRST_N,
  input  logic                    step_en,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ram_we,
  input  logic [N_IN*DATA_W-1:0]  din,
  output logic [N_OUT*DATA_W-1:0] dout,
  output logic [N_OUT-1:0]        dout_stb,
  output logic [N_IN-1:0]         chg_flags
);

  localparam int ASPACE = 2 ** ADDR_W;

  if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8 || SYNC_STAGES < 2 ||
      N_IN > DATA_W) begin : g_param_err
    $error("parallel_io_ctrl: illegal channel count or synchroniser depth");
  end

  if (windows_overlap(int'(IN_BASE), N_IN, int'(OUT_BASE), N_OUT) ||
      windows_overlap(int'(IN_BASE), N_IN, int'(STAT_ADDR), 1) ||
      windows_overlap(int'(OUT_BASE), N_OUT, int'(STAT_ADDR), 1) ||
      int'(IN_BASE) + N_IN > ASPACE || int'(OUT_BASE) + N_OUT > ASPACE) begin : g_overlap_err
    $error("parallel_io_ctrl: I/O address windows overlap or exceed the address space");
  end

  logic [N_IN-1:0]        hit_in;
  logic [N_OUT-1:0]       hit_out;
  logic                   hit_stat;
  logic                   io_hit;
  logic                   clr;
  logic [N_OUT-1:0]       wr_en;
  logic [N_IN*DATA_W-1:0] sync_in;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign hit_in[i] = (address == ADDR_W'(int'(IN_BASE) + i));

    pio_in_chan #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .iRST_N   (iRST_N),
      .din      (din[i*DATA_W +: DATA_W]),
      .clr      (clr),
      .sync_out (sync_in[i*DATA_W +: DATA_W]),
      .chg_flag (chg_flags[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out_dec
    assign hit_out[j] = (address == ADDR_W'(int'(OUT_BASE) + j));
  end

  assign hit_stat = (address == STAT_ADDR);
  assign io_hit   = (|hit_in) | (|hit_out) | hit_stat;
  assign ram_we   = we & ~io_hit;
  // A store to the status address must not act as a read, so clear requires ~we.
  assign clr      = step_en & hit_stat & ~we;
  assign wr_en    = hit_out & {N_OUT{step_en & we}};

  always_comb begin
    rdata = mem_rdata;
    if (hit_stat) rdata = DATA_W'(chg_flags);
    for (int i = 0; i < N_IN; i++)
      if (hit_in[i]) rdata = sync_in[i*DATA_W +: DATA_W];
    for (int j = 0; j < N_OUT; j++)
      if (hit_out[j]) rdata = dout[j*DATA_W +: DATA_W];
  end

  // output registers and strobes, visible one clk after the qualifying edge
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      dout     <= '0;
      dout_stb <= '0;
    end else begin
      dout_stb <= wr_en;
      for (int j = 0; j < N_OUT; j++)
        if (wr_en[j]) dout[j*DATA_W +: DATA_W] <= wdata;
    end
  end

endmodule

// File: tb/tb_parallel_io_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-indexed reference
// model of the I/O window (input history, output registers, sticky flags).
module tb_parallel_io_ctrl;

  localparam int         N_IN   = 2;
  localparam int         N_OUT  = 2;
  localparam int         SYNC   = 2;
  localparam logic [7:0] IN_B   = 8'hF0;
  localparam logic [7:0] OUT_B  = 8'hF8;
  localparam logic [7:0] STAT_A = 8'hFF;

  logic                 clk = 1'b0;
  logic                 iRST_N;
  logic                 step_en;
  logic [7:0]           address;
  logic [7:0]           wdata;
  logic                 we;
  logic [7:0]           mem_rdata;
  logic [7:0]           rdata;
  logic                 ram_we;
  logic [N_IN*8-1:0]    din;
  logic [N_OUT*8-1:0]   dout;
  logic [N_OUT-1:0]     dout_stb;
  logic [N_IN-1:0]      chg_flags;

  int checks   = 0;
  int failures = 0;

  logic [7:0] din_log [0:1023][N_IN];

  parallel_io_ctrl #(
    .DATA_W(8), .ADDR_W(8), .N_IN(N_IN), .N_OUT(N_OUT),
    .IN_BASE(IN_B), .OUT_BASE(OUT_B), .STAT_ADDR(STAT_A), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .iRST_N(iRST_N), .step_en(step_en), .address(address),
    .wdata(wdata), .we(we), .mem_rdata(mem_rdata), .rdata(rdata),
    .ram_we(ram_we), .din(din), .dout(dout), .dout_stb(dout_stb),
    .chg_flags(chg_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input value visible at the synchroniser output after k edges since reset release.
  function automatic logic [7:0] sync_at(input int ch, input int k);
    if (k < SYNC) return 8'h00;
    return din_log[k-SYNC+1][ch];
  endfunction

  function automatic logic [7:0] prev_at(input int ch, input int k);
    if (k < 1) return 8'h00;
    return sync_at(ch, k-1);
  endfunction

  task automatic test_reset();
    iRST_N = 1'b0; step_en = 0; we = 0; address = 8'h00; wdata = 0;
    mem_rdata = 8'h00; din = {8'h00, 8'hA5};
    repeat (3) tick();
    checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (dout_stb !== '0) begin failures++; $display("FAIL reset_stb got=%b exp=0", dout_stb); end
    checks++; if (chg_flags !== '0) begin failures++; $display("FAIL reset_flags got=%b exp=0", chg_flags); end
    iRST_N = 1'b1;
    tick(); tick();
    checks++; if (chg_flags !== 2'b00) begin failures++; $display("FAIL reset_flag_early got=%b exp=00", chg_flags); end
    tick();
    checks++; if (chg_flags !== 2'b01) begin failures++; $display("FAIL reset_flag_set got=%b exp=01", chg_flags); end
  endtask

  task automatic test_out_write();
    address = 8'hF9; wdata = 8'h3C; we = 1; step_en = 1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL out_ram_we got=%b exp=0", ram_we); end
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL out_pre got=%h exp=0000", dout); end
    tick();
    we = 0; step_en = 0;
    #1;
    checks++; if (dout !== 16'h3C00) begin failures++; $display("FAIL out_dout got=%h exp=3c00", dout); end
    checks++; if (dout_stb !== 2'b10) begin failures++; $display("FAIL out_stb got=%b exp=10", dout_stb); end
    checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL out_readback got=%h exp=3c", rdata); end
    tick();
    checks++; if (dout_stb !== 2'b00) begin failures++; $display("FAIL out_stb_drop got=%b exp=00", dout_stb); end
    checks++; if (dout !== 16'h3C00) begin failures++; $display("FAIL out_hold got=%h exp=3c00", dout); end
  endtask

  task automatic test_write_no_step();
    address = 8'hF8; wdata = 8'h77; we = 1; step_en = 0;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL nostep_ram_we got=%b exp=0", ram_we); end
    tick(); tick();
    checks++; if (dout !== 16'h3C00) begin failures++; $display("FAIL nostep_dout got=%h exp=3c00", dout); end
    checks++; if (dout_stb !== 2'b00) begin failures++; $display("FAIL nostep_stb got=%b exp=00", dout_stb); end
    we = 0;
  endtask

  task automatic test_in_status();
    address = STAT_A; we = 0; step_en = 1;
    tick();
    step_en = 0;
    #1;
    checks++; if (chg_flags !== 2'b00) begin failures++; $display("FAIL stat_clear0 got=%b exp=00", chg_flags); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL stat_read0 got=%h exp=00", rdata); end
    din[15:8] = 8'h7F;
    tick(); tick();
    address = 8'hF1;
    #1;
    checks++; if (rdata !== 8'h7F) begin failures++; $display("FAIL in_ch1 got=%h exp=7f", rdata); end
    checks++; if (chg_flags !== 2'b00) begin failures++; $display("FAIL in_flag_early got=%b exp=00", chg_flags); end
    tick();
    address = STAT_A;
    #1;
    checks++; if (rdata !== 8'h02) begin failures++; $display("FAIL stat_read got=%h exp=02", rdata); end
    step_en = 1;
    #1;
    checks++; if (rdata !== 8'h02) begin failures++; $display("FAIL stat_read_step got=%h exp=02", rdata); end
    tick();
    step_en = 0;
    #1;
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL stat_cleared got=%h exp=00", rdata); end
  endtask

  task automatic test_collision();
    din[7:0] = 8'h5A;
    tick(); tick();
    address = STAT_A; we = 0; step_en = 1;
    tick();
    step_en = 0;
    #1;
    checks++; if (chg_flags !== 2'b01) begin failures++; $display("FAIL collide_set_wins got=%b exp=01", chg_flags); end
    step_en = 1;
    tick();
    step_en = 0;
    #1;
    checks++; if (chg_flags !== 2'b00) begin failures++; $display("FAIL collide_then_clear got=%b exp=00", chg_flags); end
  endtask

  task automatic test_io_store_ignored();
    address = 8'hF0; wdata = 8'hEE; we = 1; step_en = 1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL instore_ram_we got=%b exp=0", ram_we); end
    tick();
    we = 0; step_en = 0;
    #1;
    checks++; if (dout !== 16'h3C00 || dout_stb !== 2'b00) begin failures++; $display("FAIL instore_state got=%h/%b exp=3c00/00", dout, dout_stb); end
    din[15:8] = 8'h11;
    repeat (3) tick();
    address = STAT_A; wdata = 8'hFF; we = 1; step_en = 1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL statstore_ram_we got=%b exp=0", ram_we); end
    tick();
    we = 0; step_en = 0;
    #1;
    checks++; if (chg_flags !== 2'b10) begin failures++; $display("FAIL statstore_noclear got=%b exp=10", chg_flags); end
  endtask

  task automatic test_ram_passthrough();
    address = 8'h10; we = 1; step_en = 1; mem_rdata = 8'h55; wdata = 8'h99;
    #1;
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL ram_we got=%b exp=1", ram_we); end
    checks++; if (rdata !== 8'h55) begin failures++; $display("FAIL ram_rdata got=%h exp=55", rdata); end
    address = 8'hF2;
    #1;
    checks++; if (ram_we !== 1'b1 || rdata !== 8'h55) begin failures++; $display("FAIL gap_addr got=%b/%h exp=1/55", ram_we, rdata); end
    tick();
    we = 0; step_en = 0;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_we_idle got=%b exp=0", ram_we); end
    checks++; if (dout !== 16'h3C00) begin failures++; $display("FAIL ram_dout got=%h exp=3c00", dout); end
  endtask

  task automatic test_reset_mid();
    address = 8'hF8; wdata = 8'h9A; we = 1; step_en = 1;
    tick();
    we = 0; step_en = 0;
    #1;
    checks++; if (dout !== 16'h3C9A || dout_stb !== 2'b01) begin failures++; $display("FAIL mid_pre got=%h/%b exp=3c9a/01", dout, dout_stb); end
    iRST_N = 1'b0;
    #1;
    checks++; if (dout !== 16'h0000) begin failures++; $display("FAIL mid_dout got=%h exp=0000", dout); end
    checks++; if (dout_stb !== 2'b00) begin failures++; $display("FAIL mid_stb got=%b exp=00", dout_stb); end
    checks++; if (chg_flags !== 2'b00) begin failures++; $display("FAIL mid_flags got=%b exp=00", chg_flags); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]         m_dout [N_OUT];
    logic [N_OUT-1:0]   m_stb;
    logic [N_IN-1:0]    m_flags;
    logic [N_OUT*8-1:0] exp_dout;
    logic [7:0]         exp_rd;
    logic               exp_we, is_io, clr_m;
    int                 e;
    iRST_N = 1'b0; din = '0; we = 0; step_en = 0; address = 8'h00;
    tick();
    iRST_N = 1'b1;
    e = 0; m_stb = '0; m_flags = '0;
    for (int j = 0; j < N_OUT; j++) m_dout[j] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: address = IN_B;
        1: address = IN_B + 8'd1;
        2: address = OUT_B;
        3: address = OUT_B + 8'd1;
        4: address = STAT_A;
        5: address = 8'($urandom);
        default: address = 8'hF0 + 8'($urandom_range(0, 15));
      endcase
      we        = ($urandom_range(0, 9) < 4);
      step_en   = 1'($urandom_range(0, 1));
      wdata     = 8'($urandom);
      mem_rdata = 8'($urandom);
      for (int ch = 0; ch < N_IN; ch++)
        if ($urandom_range(0, 3) == 0) din[ch*8 +: 8] = 8'($urandom);
      #1;
      is_io = (address >= IN_B && address < IN_B + N_IN) ||
              (address >= OUT_B && address < OUT_B + N_OUT) || (address == STAT_A);
      exp_we = we && !is_io;
      exp_rd = mem_rdata;
      for (int ch = 0; ch < N_IN; ch++) if (address == IN_B + ch) exp_rd = sync_at(ch, e);
      for (int j = 0; j < N_OUT; j++) if (address == OUT_B + j) exp_rd = m_dout[j];
      if (address == STAT_A) exp_rd = 8'(m_flags);
      for (int j = 0; j < N_OUT; j++) exp_dout[j*8 +: 8] = m_dout[j];
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, address, rdata, exp_rd); end
      checks++; if (ram_we !== exp_we) begin failures++; $display("FAIL rnd_ram_we n=%0d addr=%h got=%b exp=%b", n, address, ram_we, exp_we); end
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, dout, exp_dout); end
      checks++; if (dout_stb !== m_stb) begin failures++; $display("FAIL rnd_stb n=%0d got=%b exp=%b", n, dout_stb, m_stb); end
      checks++; if (chg_flags !== m_flags) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, chg_flags, m_flags); end
      clr_m = step_en && !we && (address == STAT_A);
      for (int ch = 0; ch < N_IN; ch++)
        m_flags[ch] = (sync_at(ch, e) != prev_at(ch, e)) || (m_flags[ch] && !clr_m);
      for (int j = 0; j < N_OUT; j++) begin
        m_stb[j] = step_en && we && (address == OUT_B + j);
        if (m_stb[j]) m_dout[j] = wdata;
      end
      e++;
      for (int ch = 0; ch < N_IN; ch++) din_log[e][ch] = din[ch*8 +: 8];
      tick();
    end
    we = 0; step_en = 0;
  endtask

  initial begin
    test_reset();
    test_out_write();
    test_write_no_step();
    test_in_status();
    test_collision();
    test_io_store_ignored();
    test_ram_passthrough();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
